bus_transfer_sequencer: RTL and testbench

- Initiator side of the shared 8-bit tri-state register bus.
- Register blocks on the bus are passive: they drive the bus on oe and load from it on ie. This block generates those oe/ie strobes.
- Accepts one transfer request at a time (source index, destination index) and sequences drive, settle and latch phases, so that exactly one register drives the bus and exactly one register latches it.
- Snoops the bus value at the latch edge and reports completion.

---
 rtl/bus_transfer_sequencer.sv | 98 +++++++++
 tb/tb_bus_transfer_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_transfer_sequencer.sv
// Initiator for the shared 8-bit tri-state register bus: sequences drive, settle and latch strobes.
// Define BUS_XFER_COUNT_EN to add a saturating completed-transfer counter (xfer_count).
module bus_transfer_sequencer #(
    parameter int N_REGS        = 8,
    parameter int IDX_W         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [IDX_W-1:0]  req_src,
    input  logic [IDX_W-1:0]  req_dst,
    output logic [N_REGS-1:0] oe,
    output logic [N_REGS-1:0] ie,
    input  logic [7:0]        bus,
    output logic              done,
    output logic              err,
`ifdef BUS_XFER_COUNT_EN
    output logic [15:0]       xfer_count,
`endif
    output logic [7:0]        last_data
);

    typedef enum logic [2:0] {IDLE, DRIVE, LATCH, DONE, ERR} state_t;

    // One extra bit so N_REGS=16 is representable in the range check.
    localparam logic [IDX_W:0] NREGS_W = (IDX_W+1)'(N_REGS);
    localparam logic [3:0]     SETTLE_LD = 4'(SETTLE_CYCLES - 1);

    state_t           state;
    logic [3:0]       cnt;
    logic [IDX_W-1:0] dst_q;
    logic             bad_req;

    function automatic logic [N_REGS-1:0] onehot(input logic [IDX_W-1:0] i);
        onehot = N_REGS'(1) << i;
    endfunction

    assign req_ready = (state == IDLE);
    assign bad_req   = (req_src == req_dst) || ({1'b0, req_src} >= NREGS_W)
                       || ({1'b0, req_dst} >= NREGS_W);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            oe        <= '0;
            ie        <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            last_data <= 8'h00;
            cnt       <= '0;
            dst_q     <= '0;
`ifdef BUS_XFER_COUNT_EN
            xfer_count <= 16'h0000;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: if (req_valid) begin
                    if (bad_req) begin
                        state <= ERR;
                        err   <= 1'b1;
                    end else begin
                        state <= DRIVE;
                        oe    <= onehot(req_src);
                        dst_q <= req_dst;
                        cnt   <= SETTLE_LD;
                    end
                end
                DRIVE: begin
                    if (cnt == 4'd0) begin
                        state <= LATCH;
                        ie    <= onehot(dst_q);
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                // Destination loads on this edge; strobes drop together so the bus idles next cycle.
                LATCH: begin
                    last_data <= bus;
                    oe        <= '0;
                    ie        <= '0;
                    done      <= 1'b1;
                    state     <= DONE;
`ifdef BUS_XFER_COUNT_EN
                    if (xfer_count != 16'hFFFF) xfer_count <= xfer_count + 16'd1;
`endif
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Bench: two sequencers (settle 1 and 4) driving modelled bus registers; scoreboard of accepted requests.
module tb_bus_transfer_sequencer;

    typedef struct {
        int         d;
        bit         is_err;
        logic [3:0] src;
        logic [3:0] dst;
        logic [7:0] data;
        int         acc;
    } xfer_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid [2];
    logic       req_ready [2];
    logic [3:0] req_src   [2];
    logic [3:0] req_dst   [2];
    logic [7:0] oe        [2];
    logic [7:0] ie        [2];
    logic [7:0] bus       [2];
    logic [7:0] last_data [2];
    logic       done      [2];
    logic       err       [2];
`ifdef BUS_XFER_COUNT_EN
    logic [15:0] xfer_count [2];
`endif

    logic [7:0] regs     [2][8];
    logic [7:0] exp_regs [2][8];
    logic       load_regs = 1'b1;
    xfer_t      sbq[$];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    int         n_good = 0;

    always #5 clk = ~clk;

    bus_transfer_sequencer #(.N_REGS(8), .IDX_W(4), .SETTLE_CYCLES(1)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_src(req_src[0]), .req_dst(req_dst[0]), .oe(oe[0]), .ie(ie[0]), .bus(bus[0]),
        .done(done[0]), .err(err[0]),
`ifdef BUS_XFER_COUNT_EN
        .xfer_count(xfer_count[0]),
`endif
        .last_data(last_data[0]));

    bus_transfer_sequencer #(.N_REGS(8), .IDX_W(4), .SETTLE_CYCLES(4)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_src(req_src[1]), .req_dst(req_dst[1]), .oe(oe[1]), .ie(ie[1]), .bus(bus[1]),
        .done(done[1]), .err(err[1]),
`ifdef BUS_XFER_COUNT_EN
        .xfer_count(xfer_count[1]),
`endif
        .last_data(last_data[1]));

    function automatic int st(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic logic [7:0] init_val(input int i);
        return 8'(8'h11 * i) ^ 8'h85;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Passive register blocks: drive on oe, load on ie.
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            bus[d] = 8'h00;
            for (int i = 0; i < 8; i++)
                if (oe[d][i]) bus[d] = bus[d] | regs[d][i];
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++)
                if (load_regs) regs[d][i] <= init_val(i);
                else if (ie[d][i]) regs[d][i] <= bus[d];
    end

    always @(negedge clk) begin : monitor
        xfer_t      t;
        int         k;
        int         fin;
        logic [7:0] eo, ei;
        logic       ed, ee, act;
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                eo = 8'h00; ei = 8'h00; ed = 1'b0; ee = 1'b0; act = 1'b0; k = 0; fin = 0;
                if (sbq.size() > 0 && sbq[0].d == d) begin
                    t   = sbq[0];
                    k   = cyc - t.acc;
                    act = (k >= 1);
                    fin = t.is_err ? 1 : st(d) + 2;
                    if (t.is_err) ee = (k == 1);
                    else begin
                        if (k >= 1 && k <= st(d) + 1) eo = 8'(1) << t.src;
                        if (k == st(d) + 1) ei = 8'(1) << t.dst;
                        ed = (k == st(d) + 2);
                    end
                end
                chk("oe", oe[d], eo);
                chk("ie", ie[d], ei);
                chk("done", done[d], ed);
                chk("err", err[d], ee);
                chk("req_ready", req_ready[d], !act);
                if (ed) chk("last_data", last_data[d], t.data);
                if (act && k >= fin) begin
                    if (!t.is_err) begin
                        exp_regs[d][t.dst] = t.data;
                        if (d == 0) n_good++;
                    end
                    void'(sbq.pop_front());
                end
                if (req_valid[d] && req_ready[d]) begin
                    t.d      = d;
                    t.src    = req_src[d];
                    t.dst    = req_dst[d];
                    t.is_err = (req_src[d] == req_dst[d]) || (req_src[d] >= 4'd8) || (req_dst[d] >= 4'd8);
                    t.data   = t.is_err ? 8'h00 : exp_regs[d][req_src[d][2:0]];
                    t.acc    = cyc;
                    sbq.push_back(t);
                end
            end
        end
    end

    task automatic wait_ready(input int d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (req_ready[d]) ok = 1'b1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic send(input int d, input int s, input int t);
        bit ok;
        @(posedge clk); #2;
        req_valid[d] = 1'b1;
        req_src[d]   = 4'(s);
        req_dst[d]   = 4'(t);
        wait_ready(d, ok);
        @(posedge clk); #2;
        req_valid[d] = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (sbq.size() == 0) ok = 1'b1;
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        bit ok;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_src[d] = 4'h0; req_dst[d] = 4'h0;
            for (int i = 0; i < 8; i++) exp_regs[d][i] = init_val(i);
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            chk("rst_oe", oe[d], 8'h00);
            chk("rst_ie", ie[d], 8'h00);
            chk("rst_done", done[d], 1'b0);
            chk("rst_err", err[d], 1'b0);
            chk("rst_last_data", last_data[d], 8'h00);
`ifdef BUS_XFER_COUNT_EN
            chk("rst_xfer_count", xfer_count[d], 16'h0000);
`endif
        end
        @(negedge clk);
        load_regs = 1'b0;
        rst = 1'b1;
        #1 chk("ready_after_rst", req_ready[0], 1'b1);

        send(0, 2, 5); wait_idle();
        chk("single_ld", last_data[0], 8'hA7);
        send(0, 3, 3); wait_idle();
        send(0, 9, 0); wait_idle();
        chk("ld_after_err", last_data[0], 8'hA7);
        send(1, 0, 7); wait_idle();
        chk("settle4_ld", last_data[1], init_val(0));

        // Back-to-back: valid stays high, second request queued during the first transfer.
        @(posedge clk); #2;
        req_valid[0] = 1'b1; req_src[0] = 4'd1; req_dst[0] = 4'd4;
        wait_ready(0, ok);
        @(posedge clk); #2;
        req_src[0] = 4'd4; req_dst[0] = 4'd6;
        wait_ready(0, ok);
        @(posedge clk); #2;
        req_valid[0] = 1'b0;
        wait_idle();
        chk("b2b_ld", last_data[0], 8'h94);

        // Reset while the latch strobe is up: destination must keep its value.
        send(0, 1, 5);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (ie[0] == 8'h20) ok = 1'b1;
        end
        chk("saw_latch", ok, 1'b1);
        #2 rst = 1'b0;
        sbq.delete();
        n_good = 0;
        #1;
        chk("rst_mid_oe", oe[0], 8'h00);
        chk("rst_mid_ie", ie[0], 8'h00);
        @(posedge clk); #1;
        chk("rst_mid_done", done[0], 1'b0);
        chk("rst_mid_dst", regs[0][5], 8'hA7);
        chk("rst_mid_ld", last_data[0], 8'h00);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("ready_after_mid_rst", req_ready[0], 1'b1);

`ifdef BUS_XFER_COUNT_EN
        send(0, 0, 1); wait_idle();
        send(0, 2, 2); wait_idle();
        send(0, 3, 4); wait_idle();
        send(0, 5, 6); wait_idle();
        chk("xfer_count", xfer_count[0], 16'd3);
        @(posedge clk); #2;
        force dut0.xfer_count = 16'hFFFF;
        @(posedge clk); #2;
        release dut0.xfer_count;
        send(0, 6, 7); wait_idle();
        chk("xfer_count_sat", xfer_count[0], 16'hFFFF);
`endif

        for (int n = 0; n < 8; n++) begin
            send(0, int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
            wait_idle();
        end

        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++)
                chk("reg_file", regs[d][i], exp_regs[d][i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
